slot_bist_master: RTL and testbench
===================================

Name: slot_bist_master

Overview:
- Bus initiator for the 32-bit memory-mapped slot interface (cs/read/write/addr/wr_data/rd_data).
- Drives a slot-attached RAM core as its master:
  - fills a window of words with a deterministic pattern;
  - reads the window back, pipelined against the slot's fixed read latency, and checks every word.
- Reports pass/fail, error count and first failing location.
- Used for power-on memory self-test and as a bring-up traffic source.

Parameters:
- ADDR_WIDTH, 5: slot address width; window addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32: slot data width.
- RD_LAT, 2: cycles from read issue to valid rd_data. Range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  2  00 fill, 01 verify, 10 fill-then-verify, 11 treated as 01.
- base_addr  in  ADDR_WIDTH  first slot address of the window.
- count  in  ADDR_WIDTH+1  words in the window, 0..2^ADDR_WIDTH.
- seed  in  DATA_WIDTH  pattern seed.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- pass  out  1  err_count==0; valid from done, held until next accepted start.
- err_count  out  ADDR_WIDTH+1  number of mismatching words.
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch.
- first_err_data  out  DATA_WIDTH  data received at the first mismatch.
- cs  out  1  slot select.
- read  out  1  slot read strobe.
- write  out  1  slot write strobe.
- addr  out  ADDR_WIDTH  slot address.
- wr_data  out  DATA_WIDTH  slot write data.
- rd_data  in  DATA_WIDTH  slot read data.

Behaviour:
- Reset:
  - All outputs go to 0 immediately, asynchronously, including cs/read/write.
  - FSM returns to IDLE and the read pipeline valids are cleared.
  - Reset mid-operation aborts with no done pulse.
- Pattern and addressing:
  - Word i (0..count-1) uses address (base_addr+i) mod 2^ADDR_WIDTH.
  - Word i uses expected data seed+i mod 2^DATA_WIDTH.
- Transaction encoding:
  - One transaction per cycle.
  - cs, addr, wr_data and the write or read strobe are all registered and valid in the same cycle.
  - write and read are never high together.
  - With cs=0, read=0 and write=0, addr and wr_data hold their last values.
- FSM states: IDLE, WR, TURN, RD, DRAIN, DONE.
  - IDLE → start=1: latch all inputs and clear results (err_count=0, first_err_*=0, pass=0).
    - count=0 → DONE.
    - mode 00 or 10 → WR.
    - Otherwise → RD.
  - WR: issue count writes on consecutive cycles.
    - Then mode 00 → DONE; mode 10 → TURN.
  - TURN: one idle cycle with strobes low, then → RD.
  - RD: issue count reads on consecutive cycles. Each read pushes {valid, addr, expected} into an RD_LAT-deep shift pipeline. Then → DRAIN.
  - DRAIN: wait until the pipeline is empty, then → DONE.
  - DONE: pulse done, set pass, → IDLE.
- Compare:
  - When a pipeline entry's valid reaches stage RD_LAT, compare rd_data with expected.
  - On mismatch, increment err_count.
  - If err_count was 0, capture first_err_addr and first_err_data.
  - err_count cannot overflow because it holds up to 2^ADDR_WIDTH.
- Latency, with the start accepted at cycle T and N=count:
  - Fill (00): strobes T+1..T+N; done at T+N+1.
  - Verify (01): reads T+1..T+N; last compare at T+N+RD_LAT; done at T+N+RD_LAT+1.
  - Fill-then-verify (10): writes T+1..T+N; TURN at T+N+1; reads T+N+2..T+2N+1; done at T+2N+RD_LAT+2.
  - count=0: done at T+1 with no strobes and pass=1.
- Boundary rules:
  - start while busy or in DONE is ignored.
  - start in the done cycle is ignored; it is accepted from the following cycle.
  - Inputs are sampled only at acceptance, so later changes have no effect.
  - count=2^ADDR_WIDTH covers every address exactly once.

Test Plan:
1. Reset: hold reset low with start=1 → all outputs stay 0 with no strobes; after release, busy=0.
2. Full test: mode 10, base 0, count 32, seed 0x10000000, ideal RAM model with RD_LAT=2 → writes addr 0..31 carrying data 0x10000000..0x1000001F; one TURN gap; 32 back-to-back reads; done at T+68; pass=1; err_count=0.
3. Wrap: mode 00, base 30, count 4, seed 0xFFFFFFFE → writes (30,0xFFFFFFFE), (31,0xFFFFFFFF), (0,0x0), (1,0x1); done at T+5.
4. Error injection:
   - Stimulus: mode 01, base 0, count 8, seed 0x100; RAM preloaded with the pattern but address 5 holds 0x104 and address 6 holds 0.
   - Response: err_count=2, first_err_addr=5, first_err_data=0x104, pass=0, done at T+11.
5. Edge commands:
   - count=0 → done at T+1, no cs, pass=1.
   - start pulsed during busy → ignored, with no change to the transaction sequence or done timing.
6. Abort: assert reset low during RD, with 3 reads in flight → cs/read drop in the same cycle, no done pulse; after release, a new mode 01 run completes normally.

Source files
------------

// File: rtl/slot_bist_master.sv
// Slot-bus memory self-test master: fills a window of words with seed+i and/or
// reads it back through a fixed-latency compare pipeline, reporting pass/fail and the first mismatch.
module slot_bist_master #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_count,
  input  logic [DATA_WIDTH-1:0] i_seed,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [ADDR_WIDTH:0]   o_err_count,
  output logic [ADDR_WIDTH-1:0] o_first_err_addr,
  output logic [DATA_WIDTH-1:0] o_first_err_data,
  output logic                  o_cs,
  output logic                  o_read,
  output logic                  o_write,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  input  logic [DATA_WIDTH-1:0] i_rd_data
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_TURN,
    S_RD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_fillThenVerify;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_seed;

  // Stage 0 is loaded together with the read strobe; stage RD_LAT lines up with valid rd_data.
  logic [RD_LAT:0]       r_pipeVld;
  logic [ADDR_WIDTH-1:0] r_pipeAddr [RD_LAT+1];
  logic [DATA_WIDTH-1:0] r_pipeExp  [RD_LAT+1];

  logic                  w_mismatch;
  logic [CW-1:0]         w_errNext;
  logic                  w_lastIssued;
  logic                  w_pipeAhead;
  logic [ADDR_WIDTH-1:0] w_idxAddr;
  logic [DATA_WIDTH-1:0] w_idxData;

  assign w_mismatch   = r_pipeVld[RD_LAT] && (i_rd_data != r_pipeExp[RD_LAT]);
  assign w_errNext    = o_err_count + CW'(w_mismatch);
  assign w_lastIssued = (r_idx == r_count);
  assign w_pipeAhead  = |r_pipeVld[RD_LAT-1:0];
  assign w_idxAddr    = r_base + r_idx[ADDR_WIDTH-1:0];
  assign w_idxData    = r_seed + DATA_WIDTH'(r_idx);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= S_IDLE;
      r_fillThenVerify <= 1'b0;
      r_base           <= '0;
      r_count          <= '0;
      r_idx            <= '0;
      r_seed           <= '0;
      r_pipeVld        <= '0;
      for (int k = 0; k <= RD_LAT; k++) begin
        r_pipeAddr[k] <= '0;
        r_pipeExp[k]  <= '0;
      end
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_pass           <= 1'b0;
      o_err_count      <= '0;
      o_first_err_addr <= '0;
      o_first_err_data <= '0;
      o_cs             <= 1'b0;
      o_read           <= 1'b0;
      o_write          <= 1'b0;
      o_addr           <= '0;
      o_wr_data        <= '0;
    end else begin
      r_pipeVld <= {r_pipeVld[RD_LAT-1:0], 1'b0};
      for (int k = 1; k <= RD_LAT; k++) begin
        r_pipeAddr[k] <= r_pipeAddr[k-1];
        r_pipeExp[k]  <= r_pipeExp[k-1];
      end

      if (w_mismatch) begin
        o_err_count <= w_errNext;
        if (o_err_count == '0) begin
          o_first_err_addr <= r_pipeAddr[RD_LAT];
          o_first_err_data <= i_rd_data;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_fillThenVerify <= (i_mode == 2'b10);
            r_base           <= i_base_addr;
            r_count          <= i_count;
            r_seed           <= i_seed;
            r_idx            <= CW'(1);
            o_err_count      <= '0;
            o_first_err_addr <= '0;
            o_first_err_data <= '0;
            o_pass           <= 1'b0;
            if (i_count == '0) begin
              r_state <= S_DONE;
              o_done  <= 1'b1;
              o_pass  <= 1'b1;
            end else if (i_mode == 2'b00 || i_mode == 2'b10) begin
              r_state   <= S_WR;
              o_busy    <= 1'b1;
              o_cs      <= 1'b1;
              o_write   <= 1'b1;
              o_addr    <= i_base_addr;
              o_wr_data <= i_seed;
            end else begin
              r_state       <= S_RD;
              o_busy        <= 1'b1;
              o_cs          <= 1'b1;
              o_read        <= 1'b1;
              o_addr        <= i_base_addr;
              r_pipeVld[0]  <= 1'b1;
              r_pipeAddr[0] <= i_base_addr;
              r_pipeExp[0]  <= i_seed;
            end
          end
        end

        S_WR: begin
          if (w_lastIssued) begin
            o_cs    <= 1'b0;
            o_write <= 1'b0;
            if (r_fillThenVerify) begin
              r_state <= S_TURN;
            end else begin
              r_state <= S_DONE;
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
              o_pass  <= (w_errNext == '0);
            end
          end else begin
            o_addr    <= w_idxAddr;
            o_wr_data <= w_idxData;
            r_idx     <= r_idx + CW'(1);
          end
        end

        S_TURN: begin
          r_state       <= S_RD;
          o_cs          <= 1'b1;
          o_read        <= 1'b1;
          o_addr        <= r_base;
          r_idx         <= CW'(1);
          r_pipeVld[0]  <= 1'b1;
          r_pipeAddr[0] <= r_base;
          r_pipeExp[0]  <= r_seed;
        end

        S_RD: begin
          if (w_lastIssued) begin
            r_state <= S_DRAIN;
            o_cs    <= 1'b0;
            o_read  <= 1'b0;
          end else begin
            o_addr        <= w_idxAddr;
            r_idx         <= r_idx + CW'(1);
            r_pipeVld[0]  <= 1'b1;
            r_pipeAddr[0] <= w_idxAddr;
            r_pipeExp[0]  <= w_idxData;
          end
        end

        // Finish on the edge that performs the final compare, so pass includes it.
        S_DRAIN: begin
          if (!w_pipeAhead) begin
            r_state <= S_DONE;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            o_pass  <= (w_errNext == '0);
          end
        end

        S_DONE: begin
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slot_bist_master.sv
// Directed bench for slot_bist_master with an ideal 2-cycle-latency slot RAM model
// and a backdoor port for preloading RAM contents.
module tb_slot_bist_master;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [AW-1:0] baseAddr = '0;
  logic [AW:0]   count = '0;
  logic [DW-1:0] seed = '0;
  logic          busy, done, pass, cs, read, write;
  logic [AW:0]   errCount;
  logic [AW-1:0] firstErrAddr, addr;
  logic [DW-1:0] firstErrData, wrData;
  logic [DW-1:0] rdData = '0;

  logic [DW-1:0] mem [32];
  logic          rdStageVld = 1'b0;
  logic [AW-1:0] rdStageAddr = '0;
  logic          bdWe = 1'b0;
  logic [AW-1:0] bdAddr = '0;
  logic [DW-1:0] bdData = '0;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int tStart, doneCyc, nWr, nRd, nBoth, nCsBad, nBusyLow, doneSeen;
  logic [AW-1:0] wrAddrLog [64];
  logic [DW-1:0] wrDataLog [64];
  int            wrCycLog  [64];
  logic [AW-1:0] rdAddrLog [64];
  int            rdCycLog  [64];

  slot_bist_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(2)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_mode(mode),
    .i_base_addr(baseAddr), .i_count(count), .i_seed(seed),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_count(errCount),
    .o_first_err_addr(firstErrAddr), .o_first_err_data(firstErrData),
    .o_cs(cs), .o_read(read), .o_write(write), .o_addr(addr),
    .o_wr_data(wrData), .i_rd_data(rdData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Ideal RAM: data for a read issued in cycle c is presented during cycle c+2.
  always @(posedge clk) begin
    if (bdWe) mem[bdAddr] <= bdData;
    else if (cs && write) mem[addr] <= wrData;
    rdStageVld  <= cs && read;
    rdStageAddr <= addr;
    if (rdStageVld) rdData <= mem[rdStageAddr];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [AW-1:0] b,
                               input logic [AW:0] n, input logic [DW-1:0] s);
    mode = m; baseAddr = b; count = n; seed = s; start = 1'b1;
    tStart = cyc;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bdWe = 1'b1; bdAddr = a; bdData = d;
    @(negedge clk);
    bdWe = 1'b0;
  endtask

  // Samples the slot bus each cycle after acceptance until done; inputs are scrambled
  // after acceptance, and an optional extra start pulse lands while busy.
  task automatic collectRun(input int budget, input int pulseAt);
    nWr = 0; nRd = 0; nBoth = 0; nCsBad = 0; nBusyLow = 0; doneCyc = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (cs && write && nWr < 64) begin
        wrAddrLog[nWr] = addr; wrDataLog[nWr] = wrData; wrCycLog[nWr] = cyc; nWr++;
      end
      if (cs && read && nRd < 64) begin
        rdAddrLog[nRd] = addr; rdCycLog[nRd] = cyc; nRd++;
      end
      if (write && read) nBoth++;
      if (cs != (write || read)) nCsBad++;
      if (k == 1) begin
        start = 1'b0; baseAddr = ~baseAddr; count = 1; seed = ~seed; mode = ~mode;
      end
      if (pulseAt != 0 && k == pulseAt) begin
        start = 1'b1; mode = 2'b01; baseAddr = 20; count = 2; seed = '0;
      end
      if (pulseAt != 0 && k == pulseAt + 1) start = 1'b0;
      if (done) begin
        doneCyc = cyc;
        break;
      end
      if (!busy) nBusyLow++;
    end
    start = 1'b0;
  endtask

  initial begin
    // Reset asserted with start high: everything must sit at zero.
    start = 1'b1; mode = 2'b10; count = 5; seed = 32'h1234;
    #3 rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst busy/done/pass", {busy, done, pass}, 3'b000);
    checkOutput("rst strobes", {cs, read, write}, 3'b000);
    checkOutput("rst err_count", errCount, 0);
    checkOutput("rst first_err", {firstErrAddr, firstErrData}, 0);
    checkOutput("rst addr/wr_data", {addr, wrData}, 0);
    start = 1'b0;
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("post-rst busy", busy, 0);
    checkOutput("post-rst cs", cs, 0);

    // Full fill-then-verify over all 32 addresses.
    applyStimulus(2'b10, 0, 32, 32'h1000_0000);
    collectRun(200, 0);
    checkOutput("full nWr", nWr, 32);
    checkOutput("full nRd", nRd, 32);
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("full wr addr %0d", i), wrAddrLog[i], i);
      checkOutput($sformatf("full wr data %0d", i), wrDataLog[i], 32'h1000_0000 + i);
      checkOutput($sformatf("full wr cyc %0d", i), wrCycLog[i], tStart + 1 + i);
      checkOutput($sformatf("full rd addr %0d", i), rdAddrLog[i], i);
      checkOutput($sformatf("full rd cyc %0d", i), rdCycLog[i], tStart + 34 + i);
    end
    checkOutput("full done cyc", doneCyc, tStart + 68);
    checkOutput("full pass", pass, 1);
    checkOutput("full err_count", errCount, 0);
    checkOutput("full both strobes", nBoth, 0);
    checkOutput("full cs vs strobe", nCsBad, 0);
    checkOutput("full busy low", nBusyLow, 0);
    @(negedge clk);
    checkOutput("full idle after", {busy, done}, 2'b00);

    // Window wraps past the top address.
    applyStimulus(2'b00, 30, 4, 32'hFFFF_FFFE);
    collectRun(40, 0);
    checkOutput("wrap nWr", nWr, 4);
    checkOutput("wrap nRd", nRd, 0);
    checkOutput("wrap w0", {wrAddrLog[0], wrDataLog[0]}, {5'd30, 32'hFFFF_FFFE});
    checkOutput("wrap w1", {wrAddrLog[1], wrDataLog[1]}, {5'd31, 32'hFFFF_FFFF});
    checkOutput("wrap w2", {wrAddrLog[2], wrDataLog[2]}, {5'd0, 32'h0});
    checkOutput("wrap w3", {wrAddrLog[3], wrDataLog[3]}, {5'd1, 32'h1});
    checkOutput("wrap done cyc", doneCyc, tStart + 5);
    checkOutput("wrap pass", pass, 1);
    @(negedge clk);
    checkOutput("wrap hold addr/data", {cs, addr, wrData}, {1'b0, 5'd1, 32'h1});
    checkOutput("wrap pass held", pass, 1);

    // Verify with two corrupted words.
    for (int i = 0; i < 8; i++) preload(i, 32'h100 + i);
    preload(5, 32'h104);
    preload(6, 32'h0);
    @(negedge clk);
    applyStimulus(2'b01, 0, 8, 32'h100);
    collectRun(40, 0);
    checkOutput("err nRd", nRd, 8);
    checkOutput("err nWr", nWr, 0);
    checkOutput("err done cyc", doneCyc, tStart + 11);
    checkOutput("err err_count", errCount, 2);
    checkOutput("err first addr", firstErrAddr, 5);
    checkOutput("err first data", firstErrData, 32'h104);
    checkOutput("err pass", pass, 0);

    // count=0 completes at once; start held into the done cycle is ignored.
    @(negedge clk);
    applyStimulus(2'b10, 3, 0, 32'h55);
    @(negedge clk);
    checkOutput("zero done at T+1", done, 1);
    checkOutput("zero pass", pass, 1);
    checkOutput("zero err cleared", {errCount, firstErrAddr}, 0);
    checkOutput("zero no cs", {cs, busy}, 2'b00);
    @(negedge clk);
    checkOutput("zero start in done ignored", {busy, done, cs}, 3'b000);

    // Accepted on the cycle right after done; a start pulse mid-run is ignored.
    applyStimulus(2'b00, 8, 6, 32'hA5A5_0000);
    collectRun(40, 3);
    checkOutput("busy-start nWr", nWr, 6);
    checkOutput("busy-start nRd", nRd, 0);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("busy-start wr %0d", i), {wrAddrLog[i], wrDataLog[i]},
                  {5'(8 + i), 32'hA5A5_0000 + i});
      checkOutput($sformatf("busy-start cyc %0d", i), wrCycLog[i], tStart + 1 + i);
    end
    checkOutput("busy-start done cyc", doneCyc, tStart + 7);
    @(negedge clk);
    checkOutput("busy-start idle after", {busy, cs}, 2'b00);

    // Abort with three reads outstanding, then a clean rerun.
    preload(5, 32'h105);
    preload(6, 32'h106);
    @(negedge clk);
    applyStimulus(2'b01, 0, 8, 32'h100);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort read active", {cs, read}, 2'b11);
    rstN = 1'b0;
    #1;
    checkOutput("abort strobes drop", {cs, read, write}, 3'b000);
    checkOutput("abort busy drop", busy, 0);
    doneSeen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("abort no done", doneSeen, 0);
    rstN = 1'b1;
    @(negedge clk);
    applyStimulus(2'b01, 0, 8, 32'h100);
    collectRun(40, 0);
    checkOutput("rerun nRd", nRd, 8);
    checkOutput("rerun done cyc", doneCyc, tStart + 11);
    checkOutput("rerun pass", pass, 1);
    checkOutput("rerun err_count", errCount, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
